// File: rtl/divider_pkg.sv
// divider_pkg: shared width, FSM states, negation helpers and 7-segment codes
package divider_pkg;
  localparam int DW = 8;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} div_state_t;
  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [DW-1:0] neg(input logic [DW-1:0] x);
    return DW'(~x + 1'b1);
  endfunction
  // |-128| wraps back to 8'h80, which is exactly 128 read as unsigned
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] x);
    return x[DW-1] ? neg(x) : x;
  endfunction
endpackage

// File: rtl/divider_signed8_hex.sv
// HexDriver: nibble to active-low 7-segment pattern
module HexDriver
  import divider_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_CODES[nibble];
endmodule

// File: rtl/divider_signed8.sv
// divider_signed8: button-driven restoring signed 8-bit divider with hex readout
module divider_signed8
  import divider_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic [DW-1:0] S,
  output logic [DW-1:0] Quot,
  output logic [DW-1:0] Rem,
  output logic          Done,
  output logic          DivZero,
  output logic          Ovf,
  output logic [6:0]    AhexU,
  output logic [6:0]    AhexL,
  output logic [6:0]    BhexU,
  output logic [6:0]    BhexL
);
  div_state_t state, next;
  logic run_q, clr_q, run_press, clr_press, sq, sr, ge;
  logic [DW-1:0] dvs, dvd, m, bmag;
  logic [DW:0] p, sh;
  logic [2:0] cnt;
  assign run_press = run_q & ~Run;
  assign clr_press = clr_q & ~ClearA_LoadB;
  assign sh = {p[DW-1:0], m[DW-1]};
  assign ge = sh >= {1'b0, bmag};
  assign Done = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = clr_press ? IDLE : run_press ? LOAD : state;
      LOAD:       next = dvs == '0 ? FIX : ITER;
      ITER:       next = cnt == '0 ? FIX : ITER;
      FIX:        next = DONE;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) state <= Reset ? IDLE : next;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_q <= 1'b1;
      clr_q <= 1'b1;
      dvs <= '0;
      dvd <= '0;
      m <= '0;
      bmag <= '0;
      p <= '0;
      cnt <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      Quot <= '0;
      Rem <= '0;
      DivZero <= 1'b0;
      Ovf <= 1'b0;
    end else begin
      run_q <= Run;
      clr_q <= ClearA_LoadB;
      case (state)
        IDLE, DONE: begin
          if (clr_press) begin
            dvs <= S;
            Quot <= '0;
            Rem <= '0;
            DivZero <= 1'b0;
            Ovf <= 1'b0;
          end else if (run_press) dvd <= S;
        end
        LOAD: begin
          m <= mag(dvd);
          bmag <= mag(dvs);
          sq <= dvd[DW-1] ^ dvs[DW-1];
          sr <= dvd[DW-1];
          p <= '0;
          cnt <= 3'd7;
        end
        ITER: begin
          p <= ge ? sh - {1'b0, bmag} : sh;
          m <= {m[DW-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          DivZero <= dvs == '0;
          Ovf <= dvs == 8'hFF && dvd == 8'h80;
          Quot <= dvs == '0 ? 8'hFF : (dvs == 8'hFF && dvd == 8'h80) ? 8'h80 : sq ? neg(m) : m;
          Rem <= dvs == '0 ? dvd : (dvs == 8'hFF && dvd == 8'h80) ? 8'h00 : sr ? neg(p[DW-1:0]) : p[DW-1:0];
        end
        default: ;
      endcase
    end
  end
  HexDriver u_ahex_u (.nibble(Rem[7:4]),  .seg(AhexU));
  HexDriver u_ahex_l (.nibble(Rem[3:0]),  .seg(AhexL));
  HexDriver u_bhex_u (.nibble(Quot[7:4]), .seg(BhexU));
  HexDriver u_bhex_l (.nibble(Quot[3:0]), .seg(BhexL));
endmodule

// File: doc/divider_signed8.md
# divider_signed8

Sequential signed 8-bit divider sharing the multiplier lab's board-level interface: divisor loaded from switches, dividend applied and started with the Run button, results on four hex displays. It is the inverse datapath of the shift-add multiplier. It uses restoring shift-subtract on magnitudes, one quotient bit per clock, and a final sign fix-up. It sits at top level in place of the multiplier processor and reuses the same button/switch/hex wiring.

## Interface
- No parameters; width fixed at 8 (constant `DW` in package).
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high; clears all state on the next rising Clk.
- Run  in  1  active-low button; press (1→0 edge) starts a division.
- ClearA_LoadB  in  1  active-low button; press loads divisor, clears results (idle only).
- S  in  8  switches; two's-complement operand.
- Quot  out  8  signed quotient.
- Rem  out  8  signed remainder.
- Done  out  1  high while result valid.
- DivZero  out  1  divisor was zero.
- Ovf  out  1  result unrepresentable (−128 / −1).
- AhexU, AhexL  out  7  each  Rem hex digits, active-low segments.
- BhexU, BhexL  out  7  each  Quot hex digits, active-low segments.

## Operation
- Buttons are sampled by Clk. A press is `prev==1 && now==0`, with one edge register per button. A held button triggers once.
- FSM states: IDLE, LOAD, ITER, FIX, DONE.
- IDLE:
  - ClearA_LoadB press: Dvs ← S; Quot, Rem, Done, DivZero, Ovf ← 0.
  - Run press: Dvd ← S → LOAD. Dvd is always taken from S; there is no chaining.
- LOAD: capture magnitudes |Dvd|, |Dvs| as 8-bit unsigned (|−128| = 128). Capture sign flags sq = sDvd^sDvs, sr = sDvd. P (9-bit partial remainder) ← 0. Count ← 7.
  - If Dvs == 0 → FIX with DivZero.
  - Else → ITER.
- ITER, one bit per cycle:
  - {P, M} shift left 1.
  - If P ≥ |Dvs|: P ← P − |Dvs| and quotient bit = 1; else quotient bit = 0.
  - Count decrements; exit to FIX after the Count==0 cycle (8 cycles).
- FIX:
  - Quot = sq ? −Qmag : Qmag.
  - Rem = sr ? −P[7:0] : P[7:0]. This is truncating division: Rem takes the sign of the dividend, and |Rem| < |Dvs|.
  - DivZero: Quot = 8'hFF, Rem = Dvd, DivZero = 1.
  - Dvd = −128 and Dvs = −1: Quot = 8'h80, Rem = 0, Ovf = 1.
  - Then → DONE.
- DONE: Done = 1, outputs held. A Run press starts a new division (→ LOAD, Done drops next cycle). A ClearA_LoadB press behaves as in IDLE and → IDLE.
- Run presses in LOAD/ITER/FIX are ignored. ClearA_LoadB presses outside IDLE/DONE are ignored. Dvs is never altered mid-operation.
- Simultaneous Run and ClearA_LoadB press: ClearA_LoadB wins.

## Timing
- Reset values: state IDLE; Dvs, Dvd, Quot, Rem = 0; Done, DivZero, Ovf = 0; edge registers = 1 (released). Hex outputs therefore show "00"/"00".
- Reset asserted at any point, including mid-ITER, aborts the operation with no partial result visible.
- Latency: press edge seen at cycle 0 (IDLE→LOAD). Then LOAD at 1, ITER 2–9, FIX 10, Done high from cycle 11.
- Divide-by-zero: Done at cycle 3.
- Quot/Rem update only on FIX; they are stable at all other times. Hex outputs are combinational from Quot/Rem.

## Structure
- Package `divider_pkg`: `DW = 8`, FSM state enum `div_state_t`, and the 7-segment encoding constants.
- Sub-module `HexDriver` (4-bit nibble → 7-bit active-low segments), instantiated four times.
- Datapath (magnitude, shift/subtract, negate) and FSM stay in `divider_signed8`. Negation is a shared two's-complement function in the package.

## Test plan
- Reset, load +9 (ClearA_LoadB), S = +108, Run → Quot = 8'h0C, Rem = 8'h00, Done at cycle 11 after edge.
- Load −9, S = +108 → Quot = 8'hF4 (−12), Rem = 0. Then S = −109 with divisor −9 → Quot = 8'h0C, Rem = 8'hFF (−1).
- Load +9, S = −109 → Quot = 8'hF4, Rem = 8'hFF. Back-to-back Run with S = +7 → Quot = 0, Rem = 8'h07, with no reload of the divisor.
- Load 0, S = +7 → DivZero = 1, Quot = 8'hFF, Rem = 8'h07, Done at cycle 3. Load −1, S = −128 → Ovf = 1, Quot = 8'h80, Rem = 0.
- Run held low for 30 cycles → exactly one division. Run pressed during ITER → ignored, and the result matches the first operands.
- Reset asserted at cycle 5 of ITER → next cycle all outputs at reset values, FSM in IDLE. A fresh load + Run then produces a correct result.
